// File: rtl/hilo_ctrl.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module   : hilo_ctrl
// Purpose  : Sequencer and HI/LO register holder sitting behind the sequential
//            multiplier and divider. Accepts MULT/DIV requests, pulses the
//            selected unit's start line, counts that unit's fixed latency,
//            captures the 64-bit result into HI/LO and pulses done. Also
//            serves MTHI/MTLO writes while idle; HI/LO are driven straight
//            from registers for MFHI/MFLO.
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
// Parameters
//   MULT_CYCLES  edges from request acceptance to capture, multiplier (2..255)
//   DIV_CYCLES   edges from request acceptance to capture, divider    (2..255)
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   mult_req     start-multiply request
//   div_req      start-divide request (multiply wins if both are high)
//   mult_on      one-cycle start pulse to the multiplier
//   div_on       one-cycle start pulse to the divider
//   mult_hi/lo   multiplier product words, sampled only at capture
//   div_quot/rem divider quotient / remainder, sampled only at capture
//   div_zero     divider flag: divisor was zero
//   mthi_we      write wdata to HI (honoured only when idle)
//   mtlo_we      write wdata to LO (honoured only when idle)
//   wdata        MTHI/MTLO data
//   hi, lo       HI/LO registers
//   busy         operation in flight
//   done         one-cycle completion pulse
//   div_zero_exc one-cycle divide-by-zero pulse, coincident with done
//-----------------------------------------------------------------------------
module hilo_ctrl #(
   parameter int MULT_CYCLES = 35,
   parameter int DIV_CYCLES  = 35
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mult_req,
   input  logic        div_req,
   output logic        mult_on,
   output logic        div_on,
   input  logic [31:0] mult_hi,
   input  logic [31:0] mult_lo,
   input  logic [31:0] div_quot,
   input  logic [31:0] div_rem,
   input  logic        div_zero,
   input  logic        mthi_we,
   input  logic        mtlo_we,
   input  logic [31:0] wdata,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done,
   output logic        div_zero_exc
);

   localparam logic [7:0] c_MULT_CNT = 8'(MULT_CYCLES);
   localparam logic [7:0] c_DIV_CNT  = 8'(DIV_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MWAIT = 2'd1,
      S_DWAIT = 2'd2
   } state_t;

   state_t      r_state,   w_state_nxt;
   logic [7:0]  r_cnt,     w_cnt_nxt;
   logic [31:0] r_hi,      w_hi_nxt;
   logic [31:0] r_lo,      w_lo_nxt;
   logic        r_mult_on, w_mult_on_nxt;
   logic        r_div_on,  w_div_on_nxt;
   logic        r_done,    w_done_nxt;
   logic        r_dzx,     w_dzx_nxt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= 8'd0;
         r_hi      <= 32'd0;
         r_lo      <= 32'd0;
         r_mult_on <= 1'b0;
         r_div_on  <= 1'b0;
         r_done    <= 1'b0;
         r_dzx     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_hi      <= w_hi_nxt;
         r_lo      <= w_lo_nxt;
         r_mult_on <= w_mult_on_nxt;
         r_div_on  <= w_div_on_nxt;
         r_done    <= w_done_nxt;
         r_dzx     <= w_dzx_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_hi_nxt      = r_hi;
      w_lo_nxt      = r_lo;
      w_mult_on_nxt = 1'b0;
      w_div_on_nxt  = 1'b0;
      w_done_nxt    = 1'b0;
      w_dzx_nxt     = 1'b0;

      case (r_state)
         S_IDLE: begin
            // MTHI/MTLO land even if a request is accepted on the same edge;
            // the later capture simply overwrites them.
            if (mthi_we) w_hi_nxt = wdata;
            if (mtlo_we) w_lo_nxt = wdata;
            if (mult_req) begin
               w_state_nxt   = S_MWAIT;
               w_cnt_nxt     = c_MULT_CNT;
               w_mult_on_nxt = 1'b1;
            end else if (div_req) begin
               w_state_nxt  = S_DWAIT;
               w_cnt_nxt    = c_DIV_CNT;
               w_div_on_nxt = 1'b1;
            end
         end

         S_MWAIT: begin
            if (r_cnt > 8'd1) begin
               w_cnt_nxt = r_cnt - 8'd1;
            end else begin
               w_hi_nxt    = mult_hi;
               w_lo_nxt    = mult_lo;
               w_done_nxt  = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end

         S_DWAIT: begin
            if (r_cnt > 8'd1) begin
               w_cnt_nxt = r_cnt - 8'd1;
            end else begin
               // Divide-by-zero leaves HI/LO untouched and flags the exception.
               if (div_zero) begin
                  w_dzx_nxt = 1'b1;
               end else begin
                  w_hi_nxt = div_rem;
                  w_lo_nxt = div_quot;
               end
               w_done_nxt  = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign mult_on      = r_mult_on;
   assign div_on       = r_div_on;
   assign hi           = r_hi;
   assign lo           = r_lo;
   assign busy         = (r_state != S_IDLE);
   assign done         = r_done;
   assign div_zero_exc = r_dzx;

endmodule
`default_nettype wire

// File: tb/tb_hilo_ctrl.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module   : tb_hilo_ctrl
// Purpose  : Directed self-checking bench for hilo_ctrl. Inputs change and
//            outputs are sampled on the falling clock edge.
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
module tb_hilo_ctrl;

   localparam int c_MULT = 35;
   localparam int c_DIV  = 35;

   logic        clk;
   logic        reset;
   logic        mult_req, div_req;
   logic        mult_on, div_on;
   logic [31:0] mult_hi, mult_lo, div_quot, div_rem;
   logic        div_zero;
   logic        mthi_we, mtlo_we;
   logic [31:0] wdata;
   logic [31:0] hi, lo;
   logic        busy, done, div_zero_exc;

   int n_checks = 0;
   int n_fail   = 0;

   // Results gathered by the operation monitor
   int   m_busy, m_mon, m_don, m_done_busy, m_dzx_busy;
   logic m_first_mon, m_first_don, m_first_done;
   logic m_fin_done, m_fin_dzx, m_tmo;

   hilo_ctrl #(.MULT_CYCLES(c_MULT), .DIV_CYCLES(c_DIV)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .mult_req     (mult_req),
      .div_req      (div_req),
      .mult_on      (mult_on),
      .div_on       (div_on),
      .mult_hi      (mult_hi),
      .mult_lo      (mult_lo),
      .div_quot     (div_quot),
      .div_rem      (div_rem),
      .div_zero     (div_zero),
      .mthi_we      (mthi_we),
      .mtlo_we      (mtlo_we),
      .wdata        (wdata),
      .hi           (hi),
      .lo           (lo),
      .busy         (busy),
      .done         (done),
      .div_zero_exc (div_zero_exc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Called at the negedge where a request was driven. Clears the request
   // after the accepting edge, optionally injects a div_req + MTHI write
   // (DEADBEEF) at sample inject_at, and follows the operation until busy
   // drops, recording the pulses it saw.
   task automatic monitor(input int inject_at);
      m_busy = 0; m_mon = 0; m_don = 0; m_done_busy = 0; m_dzx_busy = 0;
      m_first_mon = 0; m_first_don = 0; m_first_done = 0;
      m_fin_done = 0; m_fin_dzx = 0; m_tmo = 1;
      for (int i = 1; i <= 300; i++) begin
         @(negedge clk);
         if (i == 1) begin
            mult_req     = 1'b0;
            div_req      = 1'b0;
            m_first_mon  = mult_on;
            m_first_don  = div_on;
            m_first_done = done;
         end
         if (i == inject_at) begin
            div_req = 1'b1;
            mthi_we = 1'b1;
            wdata   = 32'hDEADBEEF;
         end else if (i == inject_at + 1) begin
            div_req = 1'b0;
            mthi_we = 1'b0;
         end
         if (mult_on) m_mon++;
         if (div_on)  m_don++;
         if (!busy) begin
            m_fin_done = done;
            m_fin_dzx  = div_zero_exc;
            m_tmo      = 1'b0;
            break;
         end
         m_busy++;
         if (done)         m_done_busy++;
         if (div_zero_exc) m_dzx_busy++;
      end
   endtask

   initial begin
      int n_on;

      reset = 1'b0; mult_req = 0; div_req = 0;
      mult_hi = 0; mult_lo = 0; div_quot = 0; div_rem = 0; div_zero = 0;
      mthi_we = 0; mtlo_we = 0; wdata = 0;

      // ---------------- reset then idle ----------------
      repeat (3) @(negedge clk);
      check("rst_hi",   64'(hi),   64'h0);
      check("rst_lo",   64'(lo),   64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_done", 64'(done), 64'h0);
      reset = 1'b1;
      n_on = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (mult_on || div_on || busy) n_on++;
      end
      check("idle_no_start", 64'(n_on), 64'd0);

      // ---------------- multiply ----------------
      mult_hi = 32'hFFFFFFFF; mult_lo = 32'hFFFFFFFA;
      mult_req = 1'b1;
      monitor(-5);
      check("mul_tmo",        64'(m_tmo),        64'd0);
      check("mul_on_first",   64'(m_first_mon),  64'd1);
      check("mul_on_count",   64'(m_mon),        64'd1);
      check("mul_div_on",     64'(m_don),        64'd0);
      check("mul_busy_cyc",   64'(m_busy),       64'(c_MULT));
      check("mul_done_early", 64'(m_done_busy),  64'd0);
      check("mul_done",       64'(m_fin_done),   64'd1);
      check("mul_hi",         64'(hi),           64'hFFFFFFFF);
      check("mul_lo",         64'(lo),           64'hFFFFFFFA);

      // ---------------- back-to-back divide in the done cycle ----------------
      mult_hi = 32'hA5A5A5A5; mult_lo = 32'h5A5A5A5A;
      div_quot = 32'h7; div_rem = 32'h2; div_zero = 1'b0;
      div_req = 1'b1;
      monitor(-5);
      check("div_tmo",        64'(m_tmo),        64'd0);
      check("div_done_1cyc",  64'(m_first_done), 64'd0);
      check("div_on_first",   64'(m_first_don),  64'd1);
      check("div_on_count",   64'(m_don),        64'd1);
      check("div_mult_on",    64'(m_mon),        64'd0);
      check("div_busy_cyc",   64'(m_busy),       64'(c_DIV));
      check("div_done",       64'(m_fin_done),   64'd1);
      check("div_dzx",        64'(m_fin_dzx),    64'd0);
      check("div_hi",         64'(hi),           64'h2);
      check("div_lo",         64'(lo),           64'h7);
      @(negedge clk);
      check("div_done_low",   64'(done),         64'd0);

      // ---------------- divide by zero ----------------
      mthi_we = 1'b1; wdata = 32'h11111111;
      @(negedge clk);
      mthi_we = 1'b0; mtlo_we = 1'b1; wdata = 32'h22222222;
      @(negedge clk);
      mtlo_we = 1'b0;
      check("mthi",           64'(hi),           64'h11111111);
      check("mtlo",           64'(lo),           64'h22222222);
      div_quot = 32'hCAFE0001; div_rem = 32'hCAFE0002; div_zero = 1'b1;
      div_req = 1'b1;
      monitor(-5);
      check("dz_tmo",         64'(m_tmo),        64'd0);
      check("dz_busy_cyc",    64'(m_busy),       64'(c_DIV));
      check("dz_done",        64'(m_fin_done),   64'd1);
      check("dz_exc",         64'(m_fin_dzx),    64'd1);
      check("dz_exc_early",   64'(m_dzx_busy),   64'd0);
      check("dz_hi",          64'(hi),           64'h11111111);
      check("dz_lo",          64'(lo),           64'h22222222);
      @(negedge clk);
      check("dz_exc_low",     64'(div_zero_exc), 64'd0);
      div_zero = 1'b0;

      // ---------------- conflicts while busy ----------------
      mult_hi = 32'h01234567; mult_lo = 32'h89ABCDEF;
      mult_req = 1'b1; div_req = 1'b1;
      monitor(3);
      check("cf_tmo",         64'(m_tmo),        64'd0);
      check("cf_mult_on",     64'(m_mon),        64'd1);
      check("cf_div_on",      64'(m_don),        64'd0);
      check("cf_busy_cyc",    64'(m_busy),       64'(c_MULT));
      check("cf_hi",          64'(hi),           64'h01234567);
      check("cf_lo",          64'(lo),           64'h89ABCDEF);
      @(negedge clk);
      check("cf_idle",        64'(busy),         64'd0);

      // ---------------- reset mid-operation ----------------
      mult_hi = 32'h12345678; mult_lo = 32'h9ABCDEF0;
      mult_req = 1'b1;
      @(negedge clk);
      mult_req = 1'b0;
      repeat (9) @(negedge clk);
      check("ro_busy_pre",    64'(busy),         64'd1);
      #2 reset = 1'b0;
      #1;
      check("ro_busy",        64'(busy),         64'd0);
      check("ro_done",        64'(done),         64'd0);
      check("ro_hi",          64'(hi),           64'h0);
      n_on = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done || busy || mult_on) n_on++;
      end
      check("ro_quiet",       64'(n_on),         64'd0);
      reset = 1'b1;
      @(negedge clk);
      mult_req = 1'b1;
      monitor(-5);
      check("ro2_tmo",        64'(m_tmo),        64'd0);
      check("ro2_on",         64'(m_first_mon),  64'd1);
      check("ro2_busy_cyc",   64'(m_busy),       64'(c_MULT));
      check("ro2_done",       64'(m_fin_done),   64'd1);
      check("ro2_hi",         64'(hi),           64'h12345678);
      check("ro2_lo",         64'(lo),           64'h9ABCDEF0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hilo_ctrl.md
# hilo_ctrl

Sequencer and HI/LO register holder downstream of the sequential multiplier and divider. It accepts MULT/DIV requests from the control unit and issues a one-cycle start pulse to the selected unit. It counts that unit's fixed latency, captures the 64-bit result into HI/LO and signals completion. It also serves MTHI/MTLO writes and drives HI/LO continuously for MFHI/MFLO.

## Interface
- MULT_CYCLES, 35: edges from request acceptance to result capture for the multiplier; legal 2..255
- DIV_CYCLES, 35: same for the divider; legal 2..255
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- mult_req  in  1  start-multiply request from control unit
- div_req  in  1  start-divide request from control unit
- mult_on  out  1  start pulse to multiplier
- div_on  out  1  start pulse to divider
- mult_hi  in  32  multiplier upper product word
- mult_lo  in  32  multiplier lower product word
- div_quot  in  32  divider quotient
- div_rem  in  32  divider remainder
- div_zero  in  1  divider flag: divisor was zero
- mthi_we  in  1  write wdata to HI
- mtlo_we  in  1  write wdata to LO
- wdata  in  32  data for MTHI/MTLO
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  operation in flight; control unit stalls on it
- done  out  1  one-cycle completion pulse
- div_zero_exc  out  1  one-cycle divide-by-zero pulse

## Operation
- States: IDLE, MWAIT, DWAIT. busy = (state != IDLE), decoded from registered state.
- IDLE, mult_req=1 at an edge: go to MWAIT, cnt <= MULT_CYCLES, mult_on <= 1.
- IDLE, div_req=1 and mult_req=0: go to DWAIT, cnt <= DIV_CYCLES, div_on <= 1.
- Both requests in the same cycle in IDLE: the multiply wins and the divide is dropped. The control unit never issues both.
- mult_on and div_on are registered and high for exactly one cycle, the first cycle of MWAIT/DWAIT.
- MWAIT/DWAIT: each edge with cnt > 1 decrements cnt.
- Edge where cnt == 1 in MWAIT: hi <= mult_hi, lo <= mult_lo, done <= 1, return to IDLE.
- Edge where cnt == 1 in DWAIT with div_zero=0: hi <= div_rem, lo <= div_quot, done <= 1, return to IDLE.
- Edge where cnt == 1 in DWAIT with div_zero=1: hi and lo unchanged, done <= 1, div_zero_exc <= 1, return to IDLE.
- Requests arriving while busy are ignored, with no queueing.
- MTHI/MTLO:
  - mthi_we/mtlo_we are honoured only in IDLE and ignored while busy.
  - Both asserted: both registers take wdata.
  - A write in the same IDLE cycle as an accepted request still happens; the later capture overwrites it.
- cnt is 8 bits wide. The result inputs are sampled only at the capture edge; their values at other times are don't-care.

## Timing
- Reset values: state IDLE, cnt 0, hi 0, lo 0, mult_on 0, div_on 0, done 0, div_zero_exc 0, busy 0.
- Reset mid-operation: everything clears asynchronously, no done pulse, any pending start pulse is cancelled. The first request after reset release is accepted normally.
- Request accepted at edge E0. busy is high from E0 to E_N (N = MULT_CYCLES or DIV_CYCLES), i.e. for N cycles.
- hi/lo take new values at E_N. done is high for the single cycle after E_N; busy is low in that cycle.
- A new request is accepted in that same done cycle, giving back-to-back operations N+1 edges apart.
- hi and lo are register outputs; MFHI/MFLO read them with zero added latency.

## Test plan
- Reset then idle:
  - Stimulus: hold reset low 3 cycles, release.
  - Required: hi=lo=0, busy=0; no mult_on/div_on for 10 idle cycles.
- Multiply, MULT_CYCLES=35:
  - Stimulus: mult_req pulse; bench drives mult_hi=0xFFFFFFFF, mult_lo=0xFFFFFFFA.
  - Required: mult_on high exactly 1 cycle after the request edge; busy high 35 cycles; at E35 hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulse 1 cycle.
- Divide:
  - Stimulus: div_req; bench drives div_quot=0x00000007, div_rem=0x00000002, div_zero=0.
  - Required: hi=0x00000002, lo=0x00000007 at E35; done pulse; div_zero_exc stays 0.
- Divide by zero:
  - Stimulus: preload hi=0x11111111, lo=0x22222222 via MTHI/MTLO; div_req with div_zero=1.
  - Required: hi/lo unchanged; done and div_zero_exc both pulse in the same cycle.
- Conflicts while busy:
  - Stimulus: mult_req and div_req together; then during MWAIT issue div_req and mthi_we with wdata=0xDEADBEEF.
  - Required: only mult_on fires; div_on never fires; hi equals the multiplier result, not 0xDEADBEEF.
- Reset mid-op:
  - Stimulus: reset asserted at cycle 10 of MWAIT.
  - Required: busy drops immediately with no done; a fresh mult_req completes after exactly 35 edges.
